// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the 8051 controller and the MUL AB / DIV AB unit.
// The controller side uses the master modport; the arithmetic unit uses slave.
interface mul_div_unit_if #(
    parameter int DATA_W = 8
);
    logic              i_start;
    logic              i_op;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_resA;
    logic [DATA_W-1:0] o_resB;
    logic              o_desC;
    logic              o_desOv;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_resA, o_resB, o_desC, o_desOv
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_resA, o_resB, o_desC, o_desOv
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle 8051 MUL AB (shift-add) / DIV AB (restoring) unit, one bit per clock.
// Optional macro MULDIV_DBZ_FAST_EN: DIV by zero completes in one cycle without entering RUN.
module mul_div_unit #(
    parameter int DATA_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mul_div_unit_if.slave        bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_q, op_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   res_a_q, res_a_d;
    logic [DATA_W-1:0]   res_b_q, res_b_d;
    logic                ov_q, ov_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_acc;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic                div_ok;
    logic [DATA_W:0]     div_rem;
    logic [DATA_W-1:0]   div_quo;
    logic                last_step;
    logic                accept;

    // MUL: opa = multiplicand, opb = multiplier shifted right, acc = product.
    // DIV: opa = dividend shifting into quotient, opb = divisor, acc[DATA_W:0] = partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + ({1'b0, opa_q} & {(DATA_W+1){opb_q[0]}});
        mul_acc   = {mul_sum, acc_q[DATA_W-1:1]};
        div_shift = {acc_q[DATA_W-1:0], opa_q[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_diff[DATA_W+1];
        div_rem   = div_ok ? div_diff[DATA_W:0] : div_shift;
        div_quo   = {opa_q[DATA_W-2:0], div_ok};
        last_step = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_a_d = res_a_q;
        res_b_d = res_b_q;
        ov_d    = ov_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = bus.i_start;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q) begin
                    opa_d = div_quo;
                    acc_d = {{(DATA_W-1){1'b0}}, div_rem};
                end else begin
                    acc_d = mul_acc;
                    opb_d = opb_q >> 1;
                end
                if (last_step) begin
                    state_d = ST_DONE;
                    // A zero divisor makes every trial subtraction succeed, so the
                    // datapath itself yields quotient all-ones and remainder = A.
                    if (op_q) begin
                        res_a_d = div_quo;
                        res_b_d = div_rem[DATA_W-1:0];
                        ov_d    = (opb_q == '0);
                    end else begin
                        res_a_d = mul_acc[DATA_W-1:0];
                        res_b_d = mul_acc[2*DATA_W-1:DATA_W];
                        ov_d    = |mul_acc[2*DATA_W-1:DATA_W];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = bus.i_start;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            op_d    = bus.i_op;
            opa_d   = bus.i_a;
            opb_d   = bus.i_b;
            acc_d   = '0;
`ifdef MULDIV_DBZ_FAST_EN
            if (bus.i_op && (bus.i_b == '0)) begin
                state_d = ST_DONE;
                res_a_d = '1;
                res_b_d = bus.i_a;
                ov_d    = 1'b1;
            end
`endif
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_resA  = res_a_q;
    assign bus.o_resB  = res_b_q;
    assign bus.o_desOv = ov_q;
    assign bus.o_desC  = 1'b0;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Sequential multi-cycle unit for the 8051 MUL AB and DIV AB instructions, which the combinational ALU does not cover.
- The controller issues a start pulse with operands A and B, waits for done, then writes back A, B, OV and C.
- MUL uses a shift-add multiplier; DIV uses a restoring shift-subtract divider. Each step handles one bit per clock.

Parameters:
- DATA_W, 8: operand width. Only 8 is architecturally valid for the 8051; other values are for unit test only.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  start request, one-cycle qualifier.
- i_op  input  1  0 = MUL, 1 = DIV; sampled with i_start.
- i_a  input  DATA_W  accumulator A operand; sampled with i_start.
- i_b  input  DATA_W  B register operand; sampled with i_start.
- o_busy  output  1  high while an operation is in progress.
- o_done  output  1  one-cycle pulse; results are valid.
- o_resA  output  DATA_W  MUL: product low byte. DIV: quotient.
- o_resB  output  DATA_W  MUL: product high byte. DIV: remainder.
- o_desC  output  1  carry result; always 0.
- o_desOv  output  1  MUL: product > 2^DATA_W-1. DIV: divisor was zero.

Behaviour:
- Clocking: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state = IDLE; o_busy, o_done, o_desC, o_desOv = 0; o_resA, o_resB = 0; all internal registers = 0.
- States:
  - IDLE: if i_start, latch i_op/i_a/i_b, clear step counter, go to RUN.
  - RUN: one bit step per cycle. After DATA_W steps, go to DONE.
  - DONE: o_done = 1 for exactly this cycle. Go to IDLE, or to RUN if i_start is asserted (back-to-back accept).
- Latency: start sampled on edge T. o_busy is high on cycles T+1 .. T+DATA_W. o_done pulses on cycle T+DATA_W+1 (9 cycles for DATA_W = 8).
- o_busy is low in IDLE and DONE.
- Result registers update only at RUN→DONE and hold until the next completion. Outputs are registered; nothing is combinational from inputs.
- i_start during RUN is ignored. No queuing, no error flag.
- MUL: product = A × B, 2·DATA_W bits, unsigned.
  - Product is formed in a 2·DATA_W accumulator by shift-add, LSB of multiplier first.
  - o_resA = product[DATA_W-1:0]; o_resB = product[2·DATA_W-1:DATA_W].
  - o_desOv = |o_resB; o_desC = 0.
- DIV: unsigned restoring division, MSB first.
  - Partial remainder is DATA_W+1 bits wide, so no overflow during trial subtraction.
  - o_resA = quotient; o_resB = remainder; o_desOv = 0; o_desC = 0.
- Divide by zero (B = 0):
  - o_resA = all ones (0xFF); o_resB = original A; o_desOv = 1; o_desC = 0.
  - Same latency as a normal DIV unless the optional feature is enabled.
- Boundaries:
  - 0 × anything yields 0 with OV = 0.
  - 0xFF × 0xFF yields A = 0x01, B = 0xFE, OV = 1.
  - A < B on DIV yields quotient 0, remainder A.
- Reset mid-operation: state returns to IDLE immediately and asynchronously. No o_done is produced. Previous results are cleared to 0.
- i_op, i_a and i_b are don't-care when i_start = 0. Operands are captured, so they may change after the start cycle.

Optional Feature:
- Macro: MULDIV_DBZ_FAST_EN.
- Defined: a DIV with B = 0 skips RUN. Start at edge T gives o_done at T+1, o_busy stays low, and results are as specified for divide by zero.
- Undefined: divide by zero runs the full DATA_W steps with uniform latency. Results are identical; only timing differs.

Test Plan:
- MUL A=0x50, B=0xA0, start at T → o_busy T+1..T+8; o_done at T+9; A=0x00, B=0x32, OV=1, C=0.
- MUL A=0x0C, B=0x0A → A=0x78, B=0x00, OV=0. Then MUL A=0xFF, B=0xFF → A=0x01, B=0xFE, OV=1.
- DIV A=0xFB, B=0x12 → A=0x0D, B=0x11, OV=0, C=0. Back-to-back: start asserted in the DONE cycle with DIV A=0x05, B=0x09 → A=0x00, B=0x05 nine cycles later.
- DIV A=0x55, B=0x00 → A=0xFF, B=0x55, OV=1, C=0. Done at T+9 without the macro, T+1 with MULDIV_DBZ_FAST_EN.
- Start a MUL, pulse i_start with different operands at T+3 → the second start is ignored; results match the first operands only; a single o_done is produced.
- Assert i_rst at T+4 of a DIV → o_busy drops asynchronously, no o_done, results read 0. A new start after reset completes normally.
